// File: rtl/sound_gen.sv
// Speaker driver: per-lamp square-wave tone in idle, or a four-note jingle on WIN/LOSE/HS events.
// State | meaning:  IDLE | lamp tone or silence ;  JINGLE | note table (kind, idx) drives the tone
module sound_gen #(
  parameter int TONE0_HALF = 56_818,
  parameter int TONE1_HALF = 37_936,
  parameter int TONE2_HALF = 45_126,
  parameter int TONE3_HALF = 75_757,
  parameter int LOW_HALF   = 227_272,
  parameter int NOTE_LEN   = 5_000_000,
  parameter int DIV_W      = 18,
  parameter int NOTE_W     = 24
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       WIN,
  input  logic       LOSE,
  input  logic       HS,
  input  logic       MUTE,
  output logic       SPKR,
  output logic       BUSY
);

  typedef enum logic {ST_IDLE, ST_JINGLE} state_e;
  typedef enum logic [1:0] {K_WIN, K_LOSE, K_HS} kind_e;
  typedef enum logic [2:0] {SEL_SILENT, SEL_T0, SEL_T1, SEL_T2, SEL_T3, SEL_LOW} sel_e;

  localparam logic [NOTE_W-1:0] NOTE_LOAD = NOTE_W'(NOTE_LEN - 1);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [1:0]        idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  sel_e              sel_q, sel_d, nsel;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              tone_q, tone_d;
  logic              busy_q;
  logic              win_prev_q, lose_prev_q, hs_prev_q;
  logic              arm_q;
  logic              ev_win, ev_lose, ev_hs;

  function automatic sel_e note_sel(input kind_e kind, input logic [1:0] idx);
    sel_e s;
    s = SEL_SILENT;
    case (kind)
      K_WIN: begin
        case (idx)
          2'd0:    s = SEL_T3;
          2'd1:    s = SEL_T0;
          2'd2:    s = SEL_T2;
          default: s = SEL_T1;
        endcase
      end
      K_LOSE: begin
        case (idx)
          2'd0:    s = SEL_T0;
          2'd1:    s = SEL_T3;
          default: s = SEL_LOW;
        endcase
      end
      default: s = idx[0] ? SEL_SILENT : SEL_T1;
    endcase
    return s;
  endfunction

  function automatic logic [DIV_W-1:0] half_m1(input sel_e s);
    logic [DIV_W-1:0] h;
    h = '0;
    case (s)
      SEL_T0:  h = DIV_W'(TONE0_HALF - 1);
      SEL_T1:  h = DIV_W'(TONE1_HALF - 1);
      SEL_T2:  h = DIV_W'(TONE2_HALF - 1);
      SEL_T3:  h = DIV_W'(TONE3_HALF - 1);
      SEL_LOW: h = DIV_W'(LOW_HALF - 1);
      default: h = '0;
    endcase
    return h;
  endfunction

  // arm_q blocks the first edge after reset so a level still held high is not seen as a new event
  assign ev_win  = arm_q & WIN  & ~win_prev_q;
  assign ev_lose = arm_q & LOSE & ~lose_prev_q;
  assign ev_hs   = arm_q & HS   & ~hs_prev_q;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    note_d  = note_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_lose || ev_win || ev_hs) begin
          state_d = ST_JINGLE;
          idx_d   = 2'd0;
          note_d  = NOTE_LOAD;
          kind_d  = ev_lose ? K_LOSE : (ev_win ? K_WIN : K_HS);
        end
      end
      ST_JINGLE: begin
        if (ev_lose && (kind_q != K_LOSE)) begin
          kind_d = K_LOSE;
          idx_d  = 2'd0;
          note_d = NOTE_LOAD;
        end else if (note_q == '0) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_q + 2'd1;
            note_d = NOTE_LOAD;
          end
        end else begin
          note_d = note_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    nsel = SEL_SILENT;
    if (state_d == ST_JINGLE) begin
      nsel = note_sel(kind_d, idx_d);
    end else if (LAMP_ENA) begin
      case (LAMP)
        2'd0:    nsel = SEL_T0;
        2'd1:    nsel = SEL_T1;
        2'd2:    nsel = SEL_T2;
        default: nsel = SEL_T3;
      endcase
    end
  end

  // A select change restarts the phase; an unchanged select keeps the wave continuous across notes
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (nsel != sel_q) begin
      sel_d  = nsel;
      cnt_d  = half_m1(nsel);
      tone_d = 1'b0;
    end else if (sel_q == SEL_SILENT) begin
      tone_d = 1'b0;
    end else if (cnt_q == '0) begin
      tone_d = ~tone_q;
      cnt_d  = half_m1(sel_q);
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      kind_q      <= K_WIN;
      idx_q       <= 2'd0;
      note_q      <= '0;
      sel_q       <= SEL_SILENT;
      cnt_q       <= '0;
      tone_q      <= 1'b0;
      busy_q      <= 1'b0;
      win_prev_q  <= 1'b0;
      lose_prev_q <= 1'b0;
      hs_prev_q   <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      tone_q      <= tone_d;
      busy_q      <= (state_d == ST_JINGLE);
      win_prev_q  <= WIN;
      lose_prev_q <= LOSE;
      hs_prev_q   <= HS;
      arm_q       <= 1'b1;
    end
  end

  assign SPKR = tone_q & ~MUTE;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_sound_gen.sv
// Scoreboard bench for sound_gen: expected SPKR/BUSY transitions (edge, signal, value) are queued
// by the stimulus; a negedge monitor matches every observed transition against the queue.
module tb_sound_gen;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] LAMP;
  logic       LAMP_ENA, WIN, LOSE, HS, MUTE;
  logic       SPKR, BUSY;

  typedef struct {
    int e;
    bit sig;
    bit val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  logic spkr_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   b;

  sound_gen #(
    .TONE0_HALF(3), .TONE1_HALF(4), .TONE2_HALF(5), .TONE3_HALF(6),
    .LOW_HALF(8), .NOTE_LEN(20), .DIV_W(18), .NOTE_W(24)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .LAMP(LAMP), .LAMP_ENA(LAMP_ENA),
    .WIN(WIN), .LOSE(LOSE), .HS(HS), .MUTE(MUTE),
    .SPKR(SPKR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic push(input int e, input bit sig, input bit val);
    exp_t x;
    x.e = e; x.sig = sig; x.val = val;
    sb.push_back(x);
  endtask

  // expected square wave for one select starting at edge 'start' and replaced at edge 'stop'
  task automatic push_note(input int start, input int half, input int stop);
    bit t = 1'b0;
    for (int e = start + half; e < stop; e += half) begin
      t = ~t;
      push(e, 1'b0, t);
    end
    if (t) push(stop, 1'b0, 1'b0);
  endtask

  task automatic check_trans(input bit sig, input logic val);
    int idx = -1;
    n_tests++;
    foreach (sb[i])
      if (idx < 0 && sb[i].e == edge_cnt && sb[i].sig == sig && sb[i].val == val) idx = i;
    if (idx >= 0) sb.delete(idx);
    else begin
      n_fail++;
      $display("FAIL trans_%s: edge %0d saw value %b, no such transition expected",
               sig ? "busy" : "spkr", edge_cnt - b, val);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      if (SPKR !== spkr_prev) check_trans(1'b0, SPKR);
      if (BUSY !== busy_prev) check_trans(1'b1, BUSY);
    end
    spkr_prev = SPKR;
    busy_prev = BUSY;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // drive so the new value is sampled at edge e
  task automatic go_to(input int e);
    while (edge_cnt < e - 1) @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(output int base);
    mon_en = 1'b0;
    RST_N = 1'b0; LAMP = 2'd0; LAMP_ENA = 1'b0;
    WIN = 1'b0; LOSE = 1'b0; HS = 1'b0; MUTE = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_spkr", SPKR, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    RST_N = 1'b1;
    base = edge_cnt;
    mon_en = 1'b1;
  endtask

  task automatic end_scn(input string name, input int e);
    go_to(e);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d expected transitions unseen, first at edge %0d sig %0d val %0d, required 0 left",
               name, sb.size(), sb[0].e - b, sb[0].sig, sb[0].val);
    end
    sb.delete();
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    // lamp tone, lamp 2 (half 5), enable dropped while high
    do_reset(b);
    push_note(b + 10, 5, b + 37);
    go_to(b + 10); LAMP = 2'd2; LAMP_ENA = 1'b1;
    go_to(b + 37); LAMP_ENA = 1'b0;
    end_scn("lamp", b + 50);

    // WIN jingle
    do_reset(b);
    push(b + 10, 1'b1, 1'b1); push(b + 90, 1'b1, 1'b0);
    push_note(b + 10, 6, b + 30); push_note(b + 30, 3, b + 50);
    push_note(b + 50, 5, b + 70); push_note(b + 70, 4, b + 90);
    go_to(b + 10); WIN = 1'b1;
    go_to(b + 11); WIN = 1'b0;
    end_scn("win", b + 100);

    // WIN+LOSE together: LOSE wins, LOW continuous across notes 2/3
    do_reset(b);
    push(b + 10, 1'b1, 1'b1); push(b + 90, 1'b1, 1'b0);
    push_note(b + 10, 3, b + 30); push_note(b + 30, 6, b + 50);
    push_note(b + 50, 8, b + 90);
    go_to(b + 10); WIN = 1'b1; LOSE = 1'b1;
    go_to(b + 11); WIN = 1'b0; LOSE = 1'b0;
    end_scn("lose", b + 100);

    // HS preempted by LOSE at edge 25, later WIN ignored
    do_reset(b);
    push(b + 10, 1'b1, 1'b1); push(b + 105, 1'b1, 1'b0);
    push_note(b + 10, 4, b + 25); push_note(b + 25, 3, b + 45);
    push_note(b + 45, 6, b + 65); push_note(b + 65, 8, b + 105);
    go_to(b + 10); HS = 1'b1;
    go_to(b + 11); HS = 1'b0;
    go_to(b + 25); LOSE = 1'b1;
    go_to(b + 26); LOSE = 1'b0;
    go_to(b + 60); WIN = 1'b1;
    go_to(b + 61); WIN = 1'b0;
    end_scn("preempt", b + 115);

    // MUTE for 7 cycles over lamp 0 (half 3)
    do_reset(b);
    push(b + 13, 1'b0, 1'b1); push(b + 16, 1'b0, 1'b0); push(b + 19, 1'b0, 1'b1);
    push(b + 20, 1'b0, 1'b0); push(b + 27, 1'b0, 1'b1); push(b + 28, 1'b0, 1'b0);
    push(b + 31, 1'b0, 1'b1); push(b + 34, 1'b0, 1'b0); push(b + 37, 1'b0, 1'b1);
    push(b + 38, 1'b0, 1'b0);
    go_to(b + 10); LAMP = 2'd0; LAMP_ENA = 1'b1;
    go_to(b + 20); MUTE = 1'b1;
    go_to(b + 27); MUTE = 1'b0;
    go_to(b + 38); LAMP_ENA = 1'b0;
    end_scn("mute", b + 45);

    // reset mid-jingle with WIN held
    do_reset(b);
    push(b + 10, 1'b1, 1'b1);
    push_note(b + 10, 6, b + 30);
    push(b + 33, 1'b0, 1'b1); push(b + 36, 1'b0, 1'b0); push(b + 39, 1'b0, 1'b1);
    push(b + 40, 1'b0, 1'b0); push(b + 40, 1'b1, 1'b0);
    push(b + 55, 1'b1, 1'b1);
    push_note(b + 55, 6, b + 75);
    push(b + 78, 1'b0, 1'b1);
    go_to(b + 10); WIN = 1'b1;
    go_to(b + 40); RST_N = 1'b0;
    #1;
    chk("async_rst_spkr", SPKR, 1'b0);
    chk("async_rst_busy", BUSY, 1'b0);
    go_to(b + 43); RST_N = 1'b1;
    go_to(b + 50); WIN = 1'b0;
    go_to(b + 55); WIN = 1'b1;
    end_scn("rst_mid", b + 81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
